id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline stage directly upstream of the 32-bit ALU in the RV32I core.
- Accepts a decoded-stage instruction plus register-file read data, and generates the ALU op code, both ALU operands (with EX/MEM and MEM/WB forwarding), and the writeback tag.
- Registers the result under a valid/ready handshake.
- Supports stall, flush, and operand refresh while stalled.

Parameters:
- XLEN, 32, datapath width; the only supported value is 32.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream presents an instruction
- in_ready  out  1  stage can accept this cycle
- instr  in  32  RV32 instruction word
- pc  in  32  instruction address
- rs1_data  in  32  register-file read port 1
- rs2_data  in  32  register-file read port 2
- exm_wen  in  1  EX/MEM result will be written
- exm_rd  in  5  EX/MEM destination
- exm_result  in  32  EX/MEM result
- wb_wen  in  1  MEM/WB writeback enable
- wb_rd  in  5  MEM/WB destination
- wb_result  in  32  MEM/WB data
- flush  in  1  kill the held instruction and block accept this cycle
- out_valid  out  1  ALU inputs are valid
- out_ready  in  1  downstream consumes this cycle
- alu_a  out  32  ALU operand a
- alu_b  out  32  ALU operand b
- alu_op  out  4  ALU operation code
- rd  out  5  destination register
- rd_wen  out  1  result must be written back
- pc_out  out  32  pc of the held instruction
- illegal  out  1  unsupported or malformed instruction

Behaviour:
- Reset: when rst=1 at a clock edge, out_valid, alu_a, alu_b, alu_op, rd, rd_wen, pc_out and illegal all become 0. Reset overrides flush and accept, including mid-stall.
- in_ready = !flush && (!out_valid || out_ready). It is combinational and has no dependence on in_valid.
- Accept: when in_valid && in_ready, all outputs load at the next edge and out_valid becomes 1. Latency is 1 cycle, with back-to-back throughput of 1 per cycle.
- Drain: when out_valid && out_ready && !accept, out_valid becomes 0. Other outputs hold their values; they are don't-care.
- Flush: out_valid becomes 0 at the next edge and nothing is accepted in that cycle.
- ALU op encoding: 0000 add, 0001 sll, 0010 slt, 0011 sltu, 0100 xor, 0101 srl, 0110 or, 0111 and, 1000 sub, 1101 sra.
- Decode, opcode 0110011 (R-type):
  - alu_op = {instr[30], funct3}; a = rs1; b = rs2; rd_wen = 1.
  - Legal funct7 is 0000000, or 0100000 only when funct3 is 000 or 101.
- Decode, opcode 0010011 (I-type):
  - a = rs1; b = sign-extended instr[31:20]; rd_wen = 1.
  - alu_op = {funct3==101 ? instr[30] : 0, funct3}.
  - For funct3 001/101, b = {27'b0, instr[24:20]}.
  - instr[31:25] must be 0000000, or 0100000 when funct3=101.
- Decode, opcode 0110111 (LUI): a = 0; b = {instr[31:12], 12'b0}; alu_op = 0000; rd_wen = 1.
- Decode, opcode 0010111 (AUIPC): a = pc; b = U-immediate; alu_op = 0000; rd_wen = 1.
- Any other opcode, or any illegal funct7 above: illegal=1, rd_wen=0, alu_op=0000, a=b=0. The instruction still passes the handshake.
- rd = instr[11:7]. rd_wen is forced to 0 when rd=0.
- Forwarding at accept, for each register-sourced operand with index rs≠0:
  - exm_wen && exm_rd==rs → exm_result;
  - else wb_wen && wb_rd==rs → wb_result;
  - else the rs*_data input.
  - rs=0 always yields 0 and is never forwarded.
- Stall refresh: while out_valid && !out_ready && !flush, each register-sourced operand with index≠0 matching wb_wen && wb_rd is overwritten with wb_result at the edge.
  - Immediate, pc and zero operands are never refreshed.
  - Source indices and operand-kind flags are held internally for this purpose.
- Simultaneous drain+accept in one cycle: the new instruction replaces the old, and out_valid stays 1.

Test Plan:
- Reset check: rst=1 during a stall with out_valid=1 → next cycle out_valid=0 and all outputs 0; in_ready=1 after reset.
- R-type decode: instr 0x40B50533 (sub x10,x10,x11), rs1_data=7, rs2_data=3, no forwarding → one cycle later alu_op=1000, a=7, b=3, rd=10, rd_wen=1, illegal=0.
- I-type and U-type decode:
  - srai x5,x6,4 (0x40435293) with rs1_data=0x80000000 → alu_op=1101, b=4.
  - addi x1,x0,-1 → a=0, b=0xFFFFFFFF.
  - auipc x3,0x12345 with pc=0x100 → a=0x100, b=0x12345000.
- Forwarding priority: add x4,x1,x2 with exm_rd=1/0xAA, wb_rd=1/0xBB, wb_rd also 2 only via wb → a=0xAA.
  - Repeat with exm_wen=0 → a=0xBB.
  - rs=x0 with exm_rd=0 → operand 0.
- Stall refresh and flush:
  - Hold out_ready=0 for 3 cycles; pulse wb_wen with wb_rd=rs2 and wb_result=0x55 in cycle 2 → b=0x55 when out_ready rises.
  - Assert flush with in_valid=1 → in_ready=0 and out_valid=0 next cycle.
- Illegal and throughput:
  - opcode 0000011 or R-type funct7=0000001 → illegal=1, rd_wen=0.
  - 8 back-to-back instructions with out_ready=1 → 8 consecutive out_valid cycles, each matching its input one cycle later.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: decodes RV32I ALU instructions, forwards operands,
// and holds the ALU inputs under a valid/ready handshake.
module id_ex_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            exm_wen,
  input  logic [4:0]      exm_rd,
  input  logic [XLEN-1:0] exm_result,
  input  logic            wb_wen,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_result,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  output logic [4:0]      rd,
  output logic            rd_wen,
  output logic [XLEN-1:0] pc_out,
  output logic            illegal
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned OP_W  = 4;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [REG_W-1:0] rs1_idx, rs2_idx, rd_idx;

  assign opcode  = instr[6:0];
  assign rd_idx  = instr[11:7];
  assign funct3  = instr[14:12];
  assign rs1_idx = instr[19:15];
  assign rs2_idx = instr[24:20];
  assign funct7  = instr[31:25];

  // Register state
  logic             valid_q, valid_d;
  logic [XLEN-1:0]  a_q, a_d, b_q, b_d, pc_q, pc_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [REG_W-1:0] rd_q, rd_d, src1_q, src1_d, src2_q, src2_d;
  logic             wen_q, wen_d, ill_q, ill_d;
  logic             a_reg_q, a_reg_d, b_reg_q, b_reg_d;

  // Decode results
  logic [XLEN-1:0] dec_a, dec_b, fwd_a, fwd_b;
  logic [OP_W-1:0] dec_op;
  logic            dec_a_reg, dec_b_reg, dec_legal, dec_wen;
  logic            accept;

  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [REG_W-1:0] idx,
    input logic [XLEN-1:0]  rf,
    input logic             e_wen,
    input logic [REG_W-1:0] e_rd,
    input logic [XLEN-1:0]  e_res,
    input logic             w_wen,
    input logic [REG_W-1:0] w_rd,
    input logic [XLEN-1:0]  w_res
  );
    logic [XLEN-1:0] r;
    r = rf;
    if (idx == '0)                    r = '0;
    else if (e_wen && (e_rd == idx))  r = e_res;
    else if (w_wen && (w_rd == idx))  r = w_res;
    return r;
  endfunction

  assign fwd_a = fwd_sel(rs1_idx, rs1_data, exm_wen, exm_rd, exm_result, wb_wen, wb_rd, wb_result);
  assign fwd_b = fwd_sel(rs2_idx, rs2_data, exm_wen, exm_rd, exm_result, wb_wen, wb_rd, wb_result);

  assign in_ready = !flush && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Instruction decode and operand selection
  always_comb begin
    dec_op    = '0;
    dec_a     = '0;
    dec_b     = '0;
    dec_a_reg = 1'b0;
    dec_b_reg = 1'b0;
    dec_legal = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_legal = (funct7 == F7_BASE) ||
                    ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        dec_op    = {instr[30], funct3};
        dec_a     = fwd_a;
        dec_b     = fwd_b;
        dec_a_reg = 1'b1;
        dec_b_reg = 1'b1;
      end
      OPC_OPIMM: begin
        dec_op    = {(funct3 == 3'b101) ? instr[30] : 1'b0, funct3};
        dec_a     = fwd_a;
        dec_a_reg = 1'b1;
        if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
          dec_b     = XLEN'({27'b0, instr[24:20]});
          dec_legal = (funct7 == F7_BASE) || ((funct3 == 3'b101) && (funct7 == F7_ALT));
        end else begin
          dec_b     = XLEN'({{20{instr[31]}}, instr[31:20]});
          dec_legal = 1'b1;
        end
      end
      OPC_LUI: begin
        dec_b     = XLEN'({instr[31:12], 12'b0});
        dec_legal = 1'b1;
      end
      OPC_AUIPC: begin
        dec_a     = pc;
        dec_b     = XLEN'({instr[31:12], 12'b0});
        dec_legal = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
    if (!dec_legal) begin
      dec_op    = '0;
      dec_a     = '0;
      dec_b     = '0;
      dec_a_reg = 1'b0;
      dec_b_reg = 1'b0;
    end
    dec_wen = dec_legal && (rd_idx != '0);
  end

  // Next-state: accept, flush, drain, or refresh held operands while stalled
  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    pc_d    = pc_q;
    op_d    = op_q;
    rd_d    = rd_q;
    wen_d   = wen_q;
    ill_d   = ill_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    a_reg_d = a_reg_q;
    b_reg_d = b_reg_q;
    if (accept) begin
      valid_d = 1'b1;
      a_d     = dec_a;
      b_d     = dec_b;
      pc_d    = pc;
      op_d    = dec_op;
      rd_d    = rd_idx;
      wen_d   = dec_wen;
      ill_d   = !dec_legal;
      src1_d  = rs1_idx;
      src2_d  = rs2_idx;
      a_reg_d = dec_a_reg;
      b_reg_d = dec_b_reg;
    end else if (flush) begin
      valid_d = 1'b0;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end else if (valid_q) begin
      if (a_reg_q && (src1_q != '0) && wb_wen && (wb_rd == src1_q)) a_d = wb_result;
      if (b_reg_q && (src2_q != '0) && wb_wen && (wb_rd == src2_q)) b_d = wb_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      pc_q    <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      wen_q   <= 1'b0;
      ill_q   <= 1'b0;
      src1_q  <= '0;
      src2_q  <= '0;
      a_reg_q <= 1'b0;
      b_reg_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      pc_q    <= pc_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      wen_q   <= wen_d;
      ill_q   <= ill_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      a_reg_q <= a_reg_d;
      b_reg_q <= b_reg_d;
    end
  end

  assign out_valid = valid_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign rd        = rd_q;
  assign rd_wen    = wen_q;
  assign pc_out    = pc_q;
  assign illegal   = ill_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage against a behavioural model.
module tb_id_ex_stage;

  logic        clk, rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] instr, pc, rs1_data, rs2_data, exm_result, wb_result;
  logic [31:0] alu_a, alu_b, pc_out;
  logic        exm_wen, wb_wen, rd_wen, illegal;
  logic [4:0]  exm_rd, wb_rd, rd;
  logic [3:0]  alu_op;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  id_ex_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .exm_wen(exm_wen), .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_result(wb_result),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .rd(rd),
    .rd_wen(rd_wen), .pc_out(pc_out), .illegal(illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [31:0] a, b, pc;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        wen, ill;
    logic [4:0]  s1, s2;
    logic        r1, r2;
  } exp_t;

  exp_t m;
  logic m_valid;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] d);
    if (idx == 0) return 32'h0;
    if (exm_wen && exm_rd == idx) return exm_result;
    if (wb_wen && wb_rd == idx) return wb_result;
    return d;
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] p,
                                      input logic [31:0] d1, input logic [31:0] d2);
    exp_t e;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [4:0] r1, r2;
    bit legal;
    e = '0;
    opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    r1 = ins[19:15]; r2 = ins[24:20];
    legal = 1;
    e.pc = p; e.rd = ins[11:7];
    case (opc)
      7'h33: begin
        legal = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
        e.op = {ins[30], f3};
        e.a = fwd(r1, d1); e.b = fwd(r2, d2);
        e.s1 = r1; e.s2 = r2; e.r1 = 1; e.r2 = 1;
      end
      7'h13: begin
        e.op = {(f3 == 5) ? ins[30] : 1'b0, f3};
        e.a = fwd(r1, d1); e.s1 = r1; e.r1 = 1;
        if (f3 == 1 || f3 == 5) begin
          e.b = {27'b0, r2};
          legal = (f7 == 0) || (f3 == 5 && f7 == 7'h20);
        end else begin
          e.b = {{20{ins[31]}}, ins[31:20]};
        end
      end
      7'h37: e.b = {ins[31:12], 12'b0};
      7'h17: begin e.a = p; e.b = {ins[31:12], 12'b0}; end
      default: legal = 0;
    endcase
    e.wen = legal && (e.rd != 0);
    if (!legal) begin
      e.ill = 1; e.op = 0; e.a = 0; e.b = 0; e.r1 = 0; e.r2 = 0;
    end
    return e;
  endfunction

  // One clock: check in_ready, advance the model, check outputs after the edge
  task automatic step();
    exp_t nx;
    logic nv, rdy, was_rst;
    #1;
    rdy = !flush && (!m_valid || out_ready);
    chk("in_ready", 32'(in_ready), 32'(rdy));
    nx = m; nv = m_valid; was_rst = rst;
    if (rst) begin
      nx = '0; nv = 0;
    end else if (in_valid && rdy) begin
      nx = ref_decode(instr, pc, rs1_data, rs2_data); nv = 1;
    end else if (flush || (m_valid && out_ready)) begin
      nv = 0;
    end else if (m_valid) begin
      if (m.r1 && m.s1 != 0 && wb_wen && wb_rd == m.s1) nx.a = wb_result;
      if (m.r2 && m.s2 != 0 && wb_wen && wb_rd == m.s2) nx.b = wb_result;
    end
    @(posedge clk); #1;
    m = nx; m_valid = nv;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid || was_rst) begin
      chk("alu_a", alu_a, m.a);
      chk("alu_b", alu_b, m.b);
      chk("alu_op", 32'(alu_op), 32'(m.op));
      chk("rd", 32'(rd), 32'(m.rd));
      chk("rd_wen", 32'(rd_wen), 32'(m.wen));
      chk("pc_out", pc_out, m.pc);
      chk("illegal", 32'(illegal), 32'(m.ill));
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] r1, r2, rdx;
    logic [2:0] f3, f3s;
    logic [31:0] ins;
    r1 = 5'($urandom_range(0, 3)); r2 = 5'($urandom_range(0, 3));
    rdx = 5'($urandom_range(0, 3)); f3 = 3'($urandom);
    f3s = ($urandom_range(0, 1) == 1) ? 3'b101 : 3'b001;
    case ($urandom_range(0, 7))
      0: ins = {7'h00, r2, r1, f3, rdx, 7'h33};
      1: ins = {((f3 == 0 || f3 == 5) ? 7'h20 : 7'h00), r2, r1, f3, rdx, 7'h33};
      2: ins = {12'($urandom), r1, f3, rdx, 7'h13};
      3: ins = {((f3s == 5 && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00), 5'($urandom), r1, f3s, rdx, 7'h13};
      4: ins = {20'($urandom), rdx, 7'h37};
      5: ins = {20'($urandom), rdx, 7'h17};
      6: ins = {7'($urandom), r2, r1, f3, rdx, 7'h33};
      default: ins = $urandom;
    endcase
    return ins;
  endfunction

  task automatic quiet();
    rst = 0; flush = 0; in_valid = 0; out_ready = 1;
    exm_wen = 0; exm_rd = 0; exm_result = 0;
    wb_wen = 0; wb_rd = 0; wb_result = 0;
    rs1_data = 0; rs2_data = 0; pc = 0; instr = 0;
  endtask

  task automatic issue(input logic [31:0] ins);
    in_valid = 1; instr = ins; step(); in_valid = 0;
  endtask

  initial begin
    int run;
    quiet();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0; m = '0; m_valid = 0;

    // Reset during a stall clears everything
    out_ready = 0; rs1_data = 32'h11; rs2_data = 32'h22; pc = 32'h40;
    issue(32'h40B50533);
    step();
    rst = 1; step(); rst = 0;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_alu_a", alu_a, 32'h0);
    chk("rst_pc_out", pc_out, 32'h0);
    #1 chk("rst_in_ready", 32'(in_ready), 32'h1);
    out_ready = 1;

    // R-type sub
    rs1_data = 7; rs2_data = 3;
    issue(32'h40B50533);
    chk("sub_op", 32'(alu_op), 32'h8);
    chk("sub_a", alu_a, 32'd7);
    chk("sub_b", alu_b, 32'd3);
    chk("sub_rd", 32'(rd), 32'd10);
    chk("sub_wen", 32'(rd_wen), 32'h1);
    chk("sub_ill", 32'(illegal), 32'h0);

    // I-type and U-type
    rs1_data = 32'h80000000;
    issue(32'h40435293);
    chk("srai_op", 32'(alu_op), 32'hD);
    chk("srai_b", alu_b, 32'd4);
    rs1_data = 32'h1234;
    issue(32'hFFF00093);
    chk("addi_a", alu_a, 32'h0);
    chk("addi_b", alu_b, 32'hFFFFFFFF);
    pc = 32'h100;
    issue(32'h12345197);
    chk("auipc_a", alu_a, 32'h100);
    chk("auipc_b", alu_b, 32'h12345000);

    // Forwarding priority
    rs1_data = 32'h1; rs2_data = 32'h2;
    exm_wen = 1; exm_rd = 1; exm_result = 32'hAA;
    wb_wen = 1; wb_rd = 1; wb_result = 32'hBB;
    issue(32'h00208233);
    chk("fwd_exm", alu_a, 32'hAA);
    exm_wen = 0;
    issue(32'h00208233);
    chk("fwd_wb", alu_a, 32'hBB);
    exm_wen = 1; exm_rd = 0;
    issue(32'h00200233);
    chk("fwd_x0", alu_a, 32'h0);
    exm_wen = 0; wb_wen = 0;

    // Stall refresh on rs2
    out_ready = 0;
    issue(32'h00208233);
    step();
    wb_wen = 1; wb_rd = 2; wb_result = 32'h55; step();
    wb_wen = 0; step();
    chk("refresh_b", alu_b, 32'h55);
    out_ready = 1; step();

    // Flush blocks accept
    in_valid = 1; flush = 1; instr = 32'h00208233;
    #1 chk("flush_in_ready", 32'(in_ready), 32'h0);
    step();
    chk("flush_out_valid", 32'(out_valid), 32'h0);
    flush = 0; in_valid = 0;

    // Illegal encodings
    issue(32'h00000083);
    chk("ill_load", 32'(illegal), 32'h1);
    chk("ill_load_wen", 32'(rd_wen), 32'h0);
    issue(32'h02208233);
    chk("ill_f7", 32'(illegal), 32'h1);
    chk("ill_f7_wen", 32'(rd_wen), 32'h0);

    // Back-to-back throughput
    run = 0;
    in_valid = 1; out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      instr = rand_instr(); pc = $urandom; rs1_data = $urandom; rs2_data = $urandom;
      step();
      if (out_valid) run++;
    end
    in_valid = 0;
    chk("b2b_run", 32'(run), 32'd8);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 49) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      instr     = rand_instr();
      pc        = $urandom;
      rs1_data  = $urandom;
      rs2_data  = $urandom;
      exm_wen   = 1'($urandom); exm_rd = 5'($urandom_range(0, 3)); exm_result = $urandom;
      wb_wen    = 1'($urandom); wb_rd  = 5'($urandom_range(0, 3)); wb_result  = $urandom;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
